// File: rtl/approx_mul8_seq_ctrl.sv
// Sequential 8x8 unsigned multiplier controller: one shared 4x4 sub-multiplier
// issues the LL, LH, HL and HH partials over four cycles and shift-accumulates them.
module approx_mul8_seq_ctrl #(
    parameter logic [3:0] DEFAULT_EXACT_MASK = 4'b1000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cfg_we,
    input  logic [3:0]  cfg_exact,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [7:0]  a,
    input  logic [7:0]  b,
    output logic [3:0]  mul_a,
    output logic [3:0]  mul_b,
    output logic        mul_exact,
    input  logic [7:0]  mul_prod,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] prod,
    output logic        busy
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_MUL,
        S_DONE
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [1:0]  k;
    logic [7:0]  a_q;
    logic [7:0]  b_q;
    logic [3:0]  snap;
    logic [3:0]  exact_mask;
    logic [15:0] acc;
    logic [3:0]  shift;
    logic [15:0] partial;
    logic        accept;

    assign in_ready  = (state == S_IDLE) && !rst;
    assign accept    = in_valid && in_ready;
    assign out_valid = (state == S_DONE);
    assign busy      = (state != S_IDLE);
    assign prod      = acc;
    assign partial   = {8'b0, mul_prod} << shift;

    // NOTE: every output of this block gets a default first, so no path leaves
    // a signal unassigned and no latch is inferred.
    always_comb begin
        state_next = state;
        mul_a      = 4'd0;
        mul_b      = 4'd0;
        mul_exact  = 1'b0;
        shift      = 4'd0;
        case (state)
            S_IDLE: begin
                if (accept) state_next = S_MUL;
            end
            S_MUL: begin
                mul_exact = snap[k];
                mul_a     = k[1] ? a_q[7:4] : a_q[3:0];
                mul_b     = k[0] ? b_q[7:4] : b_q[3:0];
                // Shift is 4 per high nibble involved: LL=0, LH/HL=4, HH=8.
                shift     = {1'b0, k[1] & k[0], k[1] ^ k[0], 1'b0} << 1;
                if (k == 2'd3) state_next = S_DONE;
            end
            S_DONE: begin
                if (out_ready) state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments, so the snapshot
    // below samples exact_mask before a same-cycle config write lands.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            k          <= 2'd0;
            acc        <= 16'd0;
            a_q        <= 8'd0;
            b_q        <= 8'd0;
            snap       <= 4'd0;
            exact_mask <= DEFAULT_EXACT_MASK;
        end else begin
            state <= state_next;
            if (cfg_we) exact_mask <= cfg_exact;
            if (accept) begin
                a_q  <= a;
                b_q  <= b;
                snap <= exact_mask;
                acc  <= 16'd0;
                k    <= 2'd0;
            end
            if (state == S_MUL) begin
                acc <= acc + partial;
                k   <= k + 2'd1;
            end
        end
    end

endmodule

// File: tb/tb_approx_mul8_seq_ctrl.sv
// Scoreboard bench for approx_mul8_seq_ctrl: a stub sub-multiplier pair plus a
// quadrant-sum reference model, directed scenarios and a randomized phase.
module tb_approx_mul8_seq_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        cfg_we;
    logic [3:0]  cfg_exact;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  a;
    logic [7:0]  b;
    logic [3:0]  mul_a;
    logic [3:0]  mul_b;
    logic        mul_exact;
    logic [7:0]  mul_prod;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] prod;
    logic        busy;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [15:0] sb[$];
    logic [3:0]  model_mask = 4'b1000;
    bit          stub_ff = 1'b0;

    approx_mul8_seq_ctrl #(.DEFAULT_EXACT_MASK(4'b1000)) dut (
        .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_exact(cfg_exact),
        .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
        .mul_a(mul_a), .mul_b(mul_b), .mul_exact(mul_exact), .mul_prod(mul_prod),
        .out_valid(out_valid), .out_ready(out_ready), .prod(prod), .busy(busy)
    );

    always #5 clk = ~clk;

    // Approximate core: multiply only the top two bits of each nibble.
    function automatic int sub_mul(int x, int y, bit exact);
        if (stub_ff) return 255;
        if (exact) return x * y;
        return ((x / 4) * (y / 4)) * 16;
    endfunction

    always_comb mul_prod = 8'(sub_mul(int'(mul_a), int'(mul_b), mul_exact));

    // Reference: sum of the four nibble products weighted by 16^(high nibbles used).
    function automatic logic [15:0] model_product(int av, int bv, logic [3:0] mask);
        int sum = 0;
        for (int q = 0; q < 4; q++) begin
            int ah = q / 2;
            int bh = q % 2;
            int an = ah ? av / 16 : av % 16;
            int bn = bh ? bv / 16 : bv % 16;
            sum += sub_mul(an, bn, mask[q]) * (16 ** (ah + bh));
        end
        return 16'(sum % 65536);
    endfunction

    task automatic check(string name, logic [31:0] actual, logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Monitor: inputs change just after posedge, so negedge sees what the next edge will.
    always @(negedge clk) begin
        if (rst) begin
            sb.delete();
            model_mask = 4'b1000;
        end else begin
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL sb_underflow: got result 0x%0h, expected none", prod);
                end else begin
                    check("sb_prod", prod, sb.pop_front());
                end
            end
            if (in_valid && in_ready) sb.push_back(model_product(int'(a), int'(b), model_mask));
            if (cfg_we) model_mask = cfg_exact;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_mask(logic [3:0] m);
        cfg_we = 1'b1;
        cfg_exact = m;
        tick();
        cfg_we = 1'b0;
    endtask

    // Present one operand pair while idle; returns in the first MUL cycle (k=0).
    task automatic start_op(logic [7:0] av, logic [7:0] bv);
        a = av;
        b = bv;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic wait_out(string name, int max_cycles);
        for (int i = 0; i < max_cycles && !out_valid; i++) tick();
        check(name, out_valid, 1'b1);
    endtask

    task automatic check_step(string name, int ea, int eb, bit ee);
        check({name, "_mul_a"}, mul_a, ea);
        check({name, "_mul_b"}, mul_b, eb);
        check({name, "_mul_exact"}, mul_exact, ee);
    endtask

    initial begin
        logic [15:0] held;
        rst = 1'b1; cfg_we = 1'b0; cfg_exact = 4'd0; in_valid = 1'b0;
        a = 8'd0; b = 8'd0; out_ready = 1'b1;
        tick(); tick();
        check("rst_in_ready", in_ready, 1'b0);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_prod", prod, 16'd0);
        check("rst_mul", {mul_a, mul_b, mul_exact}, 9'd0);
        rst = 1'b0;
        #1 check("rel_in_ready", in_ready, 1'b1);

        // Step order with the default mask.
        start_op(8'h12, 8'h34);
        check("step_busy", busy, 1'b1);
        check_step("step0", 2, 4, 0); tick();
        check_step("step1", 2, 3, 0); tick();
        check_step("step2", 1, 4, 0); tick();
        check_step("step3", 1, 3, 1); tick();
        check("step_done", out_valid, 1'b1);
        check("step_idle_mul", {mul_a, mul_b, mul_exact}, 9'd0);
        tick();

        // Exact full scale and latency.
        set_mask(4'b1111);
        start_op(8'hFF, 8'hFF);
        tick(); tick(); tick();
        check("lat_not_yet", out_valid, 1'b0);
        tick();
        check("lat_valid", out_valid, 1'b1);
        check("full_prod", prod, 16'hFE01);
        tick();
        check("full_back_idle", in_ready, 1'b1);

        // Back-pressure.
        out_ready = 1'b0;
        start_op(8'($urandom), 8'($urandom));
        wait_out("bp_timeout", 8);
        held = prod;
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'($urandom);
            a = 8'($urandom);
            b = 8'($urandom);
            tick();
            check("bp_valid", out_valid, 1'b1);
            check("bp_prod", prod, held);
            check("bp_in_ready", in_ready, 1'b0);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        tick();
        check("bp_release", in_ready, 1'b1);

        // Wrap with a saturated stub.
        stub_ff = 1'b1;
        start_op(8'($urandom), 8'($urandom));
        wait_out("wrap_timeout", 8);
        check("wrap_prod", prod, 16'h1FDF);
        tick();
        stub_ff = 1'b0;

        // Reset mid-operation.
        start_op(8'hA5, 8'h5A);
        tick();
        rst = 1'b1;
        tick();
        check("mrst_valid", out_valid, 1'b0);
        check("mrst_prod", prod, 16'd0);
        check("mrst_busy", busy, 1'b0);
        rst = 1'b0;
        start_op(8'd3, 8'd5);
        check("mrst_mask_k0", mul_exact, 1'b0);
        tick(); tick(); tick();
        check("mrst_mask_k3", mul_exact, 1'b1);
        wait_out("mrst_timeout1", 8);
        tick();
        set_mask(4'b1111);
        start_op(8'd3, 8'd5);
        wait_out("mrst_timeout2", 8);
        check("mrst_prod15", prod, 16'd15);
        tick();

        // Config snapshot: write during MUL, then a write coinciding with accept.
        set_mask(4'b0101);
        start_op(8'($urandom), 8'($urandom));
        cfg_we = 1'b1;
        cfg_exact = 4'b1111;
        check("snap_k0", mul_exact, 1'b1); tick();
        cfg_we = 1'b0;
        check("snap_k1", mul_exact, 1'b0); tick();
        check("snap_k2", mul_exact, 1'b1); tick();
        check("snap_k3", mul_exact, 1'b0);
        wait_out("snap_timeout", 8);
        tick();
        cfg_we = 1'b1;
        cfg_exact = 4'b0000;
        start_op(8'($urandom), 8'($urandom));
        cfg_we = 1'b0;
        for (int s = 0; s < 4; s++) begin
            check("snap_next", mul_exact, 1'b1);
            tick();
        end
        wait_out("snap_timeout2", 8);
        tick();

        // Randomized traffic; the scoreboard checks every result.
        for (int i = 0; i < 1500; i++) begin
            in_valid  = ($urandom_range(9) < 6);
            a         = 8'($urandom);
            b         = 8'($urandom);
            out_ready = ($urandom_range(9) < 7);
            cfg_we    = ($urandom_range(15) == 0);
            cfg_exact = 4'($urandom);
            tick();
        end
        in_valid = 1'b0;
        cfg_we = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 20 && (sb.size() != 0 || busy); i++) tick();
        check("drain", sb.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/approx_mul8_seq_ctrl.md
# approx_mul8_seq_ctrl

Sequencer that computes an 8x8 unsigned product by time-multiplexing one shared 4x4 sub-multiplier over four cycles. Operands are accepted on a valid/ready handshake and split into nibbles. The block issues the LL, LH, HL and HH partial products in turn, selecting the exact or approximate sub-multiplier per quadrant. It then shift-accumulates the partials into a 16-bit result. It sits between the operand source and a shared sub-multiplier pair (exact core plus approximate core, muxed by `mul_exact`), replacing the four-instance parallel 8x8 structure where area matters more than throughput.

## Interface
- `DEFAULT_EXACT_MASK`, 4'b1000: reset value of the quadrant exactness register. Bit0=LL, bit1=LH, bit2=HL, bit3=HH; 1 selects the exact core.
- `clk`  in  1  single clock, all state on rising edge
- `rst`  in  1  synchronous, active-high reset
- `cfg_we`  in  1  write enable for the exactness register
- `cfg_exact`  in  4  new exactness mask, written when `cfg_we`=1
- `in_valid`  in  1  operand pair valid
- `in_ready`  out  1  block can accept operands
- `a`, `b`  in  8 each  unsigned operands
- `mul_a`, `mul_b`  out  4 each  nibble operands to the shared sub-multiplier
- `mul_exact`  out  1  1 selects the exact core, 0 the approximate core
- `mul_prod`  in  8  sub-multiplier result, combinational, same cycle
- `out_valid`  out  1  result valid
- `out_ready`  in  1  consumer accepts the result
- `prod`  out  16  accumulated product
- `busy`  out  1  high in MUL or DONE

## Operation
- **States:** IDLE, MUL, DONE. A 2-bit step counter `k` runs 0..3 inside MUL.
- **IDLE:**
  - `in_ready`=1.
  - On `in_valid`&&`in_ready`: latch `a`, `b` and a snapshot of the exactness register; clear the accumulator; set `k`=0; go to MUL.
- **MUL, per step:**
  - k=0: `mul_a`=a[3:0], `mul_b`=b[3:0], shift 0.
  - k=1: `mul_a`=a[3:0], `mul_b`=b[7:4], shift 4.
  - k=2: `mul_a`=a[7:4], `mul_b`=b[3:0], shift 4.
  - k=3: `mul_a`=a[7:4], `mul_b`=b[7:4], shift 8.
- **MUL, each cycle:**
  - `mul_exact` = snapshot bit k.
  - acc <= acc + (`mul_prod` << shift), truncated to 16 bits (modulo 2^16). Wrap is only reachable with approximate cores whose outputs exceed 225.
  - At k=3, go to DONE.
- **DONE:**
  - `out_valid`=1, `prod`=acc.
  - On `out_ready`=1: go to IDLE.
  - `prod` and `out_valid` hold stable while `out_ready`=0.
- `in_valid` outside IDLE is ignored; operands are not captured.
- **Config writes:**
  - `cfg_we` writes the exactness register in any state.
  - An in-flight operation uses its snapshot, so a write affects the next accepted operation only.
  - If `cfg_we` coincides with an accept, the snapshot takes the old value.
- **Outside MUL:** `mul_a`=`mul_b`=0, `mul_exact`=0.

## Timing
- **Reset (sync, `rst`=1 at a clock edge):**
  - state=IDLE, k=0, acc=0, `prod`=0.
  - `out_valid`=0, `busy`=0, `mul_a`=`mul_b`=0, `mul_exact`=0.
  - Exactness register = `DEFAULT_EXACT_MASK`.
  - `in_ready`=0 while `rst` is high; 1 on the first cycle after reset is released.
- Reset mid-MUL or in DONE aborts the operation; no `out_valid` is produced for it.
- **Latency:**
  - Accept at edge T; MUL occupies cycles T+1..T+4.
  - `out_valid` rises at T+5.
  - If `out_ready`=1 at T+5, the result transfers and the block is back in IDLE with `in_ready`=1 at T+6.
- Sustained throughput is 1 result per 6 cycles.
- `in_ready` is combinational from state (IDLE && !rst). `out_valid` and `prod` are registered.
- `mul_a`, `mul_b` and `mul_exact` are decoded from registered state/k. The `mul_prod` path must close within one cycle.

## Test plan
- **Exact full-scale:** cfg_exact=4'b1111, a=0xFF, b=0xFF, out_ready=1 → `prod`=0xFE01 (65025), `out_valid` rises exactly 5 cycles after accept.
- **Step order and mode:** default mask, a=0x12, b=0x34 → (`mul_a`,`mul_b`,`mul_exact`) = (2,4,0), (2,3,0), (1,4,0), (1,3,1) on cycles T+1..T+4.
- **Back-pressure:** hold `out_ready`=0 for 10 cycles after `out_valid` → `prod` and `out_valid` stable; `in_ready`=0; `in_valid` pulses ignored; release → IDLE the next cycle.
- **Wrap:** stub `mul_prod`=0xFF always → `prod`=0x1FDF (73695 mod 2^16).
- **Reset mid-operation:** assert `rst` at T+2 → next cycle state is IDLE, `out_valid`=0, `prod`=0, exactness register = 4'b1000. A new operation (a=3, b=5, mask 4'b1111) then yields 15.
- **Config snapshot:** `cfg_we` with 4'b1111 during MUL → current op's `mul_exact` unchanged; the next op shows `mul_exact`=1 on all four steps.
